sequenciador_captura_faces: RTL and testbench

SEQUENCIADOR_CAPTURA_FACES -- requirements
Module: sequenciador_captura_faces

---
 rtl/sequenciador_captura_faces.sv | 123 ++++++++++++
 tb/tb_sequenciador_captura_faces.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sequenciador_captura_faces.sv
// sequenciador_captura_faces: steps the cube through NUM_FACES captures and rotations,
// retrying a stalled capture up to MAX_TENTATIVAS times and aborting on any timeout.
module sequenciador_captura_faces #(
    parameter int NUM_FACES      = 6,
    parameter int TIMEOUT_CICLOS = 50_000_000,
    parameter int MAX_TENTATIVAS = 3
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       iniciar,
    input  logic       captura_pronto,
    input  logic       movimento_pronto,
    output logic       inicia_captura,
    output logic       solicita_movimento,
    output logic [2:0] face,
    output logic       pronto,
    output logic       erro,
    output logic [3:0] db_estado
);
    localparam int TW = (TIMEOUT_CICLOS > 1) ? $clog2(TIMEOUT_CICLOS) : 1;
    localparam logic [TW-1:0] T_MAX = TW'(TIMEOUT_CICLOS - 1);
    localparam logic [2:0] F_MAX = 3'(NUM_FACES - 1);
    localparam logic [2:0] N_MAX = 3'(MAX_TENTATIVAS - 1);

    typedef enum logic [3:0] {
        INICIAL          = 4'd0,
        PREPARA          = 4'd1,
        DISPARA          = 4'd2,
        ESPERA_CAPTURA   = 4'd3,
        PROXIMA_FACE     = 4'd4,
        MOVIMENTA        = 4'd5,
        ESPERA_MOVIMENTO = 4'd6,
        FINAL            = 4'd7,
        FALHA            = 4'd8
    } estado_t;

    estado_t       estado_q, estado_d;
    logic [2:0]    face_q, face_d, tent_q, tent_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          inicia_q, inicia_d, solicita_q, solicita_d, pronto_q, pronto_d, erro_q, erro_d;

    always_comb begin
        estado_d = estado_q;
        face_d   = face_q;
        tent_d   = tent_q;
        timer_d  = timer_q;
        case (estado_q)
            INICIAL: estado_d = iniciar ? PREPARA : INICIAL;
            PREPARA: begin
                face_d   = '0;
                tent_d   = '0;
                estado_d = DISPARA;
            end
            DISPARA: begin
                timer_d  = '0;
                estado_d = ESPERA_CAPTURA;
            end
            ESPERA_CAPTURA: begin
                timer_d = timer_q + TW'(1);
                if (captura_pronto) begin
                    estado_d = PROXIMA_FACE;
                end else if (timer_q == T_MAX) begin
                    estado_d = (tent_q == N_MAX) ? FALHA : DISPARA;
                    tent_d   = (tent_q == N_MAX) ? tent_q : tent_q + 3'd1;
                end
            end
            PROXIMA_FACE: begin
                estado_d = (face_q == F_MAX) ? FINAL : MOVIMENTA;
                face_d   = (face_q == F_MAX) ? face_q : face_q + 3'd1;
                tent_d   = (face_q == F_MAX) ? tent_q : 3'd0;
            end
            MOVIMENTA: begin
                timer_d  = '0;
                estado_d = ESPERA_MOVIMENTO;
            end
            ESPERA_MOVIMENTO: begin
                timer_d = timer_q + TW'(1);
                if (movimento_pronto) estado_d = DISPARA;
                else if (timer_q == T_MAX) estado_d = FALHA;
            end
            FINAL:   estado_d = iniciar ? PREPARA : FINAL;
            FALHA:   estado_d = iniciar ? PREPARA : FALHA;
            default: estado_d = INICIAL;
        endcase
    end

    // Control outputs are registered from the present state, so they trail it by one cycle.
    always_comb begin
        inicia_d   = (estado_q == DISPARA);
        solicita_d = (estado_q == MOVIMENTA) || (estado_q == ESPERA_MOVIMENTO);
        pronto_d   = (estado_q == FINAL);
        erro_d     = (estado_q == FALHA);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            estado_q   <= INICIAL;
            face_q     <= '0;
            tent_q     <= '0;
            timer_q    <= '0;
            inicia_q   <= 1'b0;
            solicita_q <= 1'b0;
            pronto_q   <= 1'b0;
            erro_q     <= 1'b0;
        end else begin
            estado_q   <= estado_d;
            face_q     <= face_d;
            tent_q     <= tent_d;
            timer_q    <= timer_d;
            inicia_q   <= inicia_d;
            solicita_q <= solicita_d;
            pronto_q   <= pronto_d;
            erro_q     <= erro_d;
        end
    end

    assign inicia_captura     = inicia_q;
    assign solicita_movimento = solicita_q;
    assign pronto             = pronto_q;
    assign erro               = erro_q;
    assign face               = face_q;
    assign db_estado          = (estado_q <= FALHA) ? estado_q : 4'b1001;
endmodule

// File: tb/tb_sequenciador_captura_faces.sv
// tb_sequenciador_captura_faces: randomized runs against a per-face outcome model,
// with a scoreboard of expected capture pulses popped by an independent monitor.
module tb_sequenciador_captura_faces;
    localparam int NF = 6;
    localparam int TO = 8;
    localparam int MT = 3;

    typedef struct {
        logic [2:0] f;
        int         gap;
    } exp_t;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       iniciar = 1'b0;
    logic       captura_pronto = 1'b0;
    logic       movimento_pronto = 1'b0;
    logic       inicia_captura, solicita_movimento, pronto, erro;
    logic [2:0] face;
    logic [3:0] db_estado;

    int   checks = 0;
    int   fails = 0;
    exp_t sb[$];
    int   cap_withhold[8];
    bit   mov_give[8];
    int   cap_d_fix = 0;
    int   mov_d_fix = 0;
    int   run_id = 0;
    int   cyc = 0;
    int   last_pulse = 0;
    int   mov_count = 0;
    int   cur_len = 0;
    int   last_len = 0;
    bit   mov_prev = 0;

    sequenciador_captura_faces #(
        .NUM_FACES(NF),
        .TIMEOUT_CICLOS(TO),
        .MAX_TENTATIVAS(MT)
    ) dut (
        .clock(clock),
        .reset(reset),
        .iniciar(iniciar),
        .captura_pronto(captura_pronto),
        .movimento_pronto(movimento_pronto),
        .inicia_captura(inicia_captura),
        .solicita_movimento(solicita_movimento),
        .face(face),
        .pronto(pronto),
        .erro(erro),
        .db_estado(db_estado)
    );

    always #5 clock = ~clock;

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            fails++;
            $display("FAIL %s actual=%0d expected=%0d", n, a, e);
        end
    endtask

    // Per run: each face gets (withheld+1) capture attempts up to MT; a withheld rotation aborts.
    task automatic model(output bit ok, output logic [2:0] f_end, output int nmov, output bit mov_to);
        ok = 0;
        f_end = '0;
        nmov = 0;
        mov_to = 0;
        for (int f = 0; f < NF; f++) begin
            for (int a = 0; a <= cap_withhold[f] && a < MT; a++) sb.push_back('{3'(f), (a > 0) ? TO + 1 : 0});
            if (cap_withhold[f] >= MT) begin
                f_end = 3'(f);
                return;
            end
            if (f == NF - 1) begin
                ok = 1;
                f_end = 3'(f);
                return;
            end
            nmov++;
            if (!mov_give[f + 1]) begin
                f_end = 3'(f + 1);
                mov_to = 1;
                return;
            end
        end
    endtask

    task automatic set_plan(input int cd, input int md);
        for (int i = 0; i < 8; i++) begin
            cap_withhold[i] = 0;
            mov_give[i] = 1;
        end
        cap_d_fix = cd;
        mov_d_fix = md;
    endtask

    // Scoreboard monitor: every capture pulse must match the next expected face/spacing.
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            cyc++;
            if (inicia_captura) begin
                checks++;
                if (sb.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_pulse face=%0d expected no pulse", face);
                end else begin
                    e = sb.pop_front();
                    if (face !== e.f || (e.gap != 0 && cyc - last_pulse != e.gap)) begin
                        fails++;
                        $display("FAIL pulse face=%0d gap=%0d expected face=%0d gap=%0d", face, cyc - last_pulse, e.f, e.gap);
                    end
                end
                last_pulse = cyc;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clock);
            if (solicita_movimento) begin
                if (!mov_prev) mov_count++;
                cur_len++;
            end else if (mov_prev) begin
                last_len = cur_len;
                cur_len = 0;
            end
            mov_prev = solicita_movimento;
        end
    end

    // Capture responder: withholds the first cap_withhold[face] attempts of each face.
    initial begin
        int att, lf, lrun, d;
        att = 0;
        lf = -1;
        lrun = -1;
        forever begin
            @(negedge clock);
            if (inicia_captura) begin
                att = (run_id != lrun || int'(face) != lf) ? 0 : att + 1;
                lrun = run_id;
                lf = int'(face);
                if (att >= cap_withhold[face]) begin
                    d = (cap_d_fix != 0) ? cap_d_fix : $urandom_range(1, 7);
                    repeat (d) @(posedge clock);
                    #1 captura_pronto = 1'b1;
                    @(posedge clock);
                    #1 captura_pronto = 1'b0;
                end
            end
        end
    end

    initial begin
        bit prev;
        int d;
        prev = 0;
        forever begin
            @(negedge clock);
            if (solicita_movimento && !prev && mov_give[face]) begin
                prev = 1;
                d = (mov_d_fix != 0) ? mov_d_fix : $urandom_range(1, 7);
                repeat (d) @(posedge clock);
                #1 movimento_pronto = 1'b1;
                @(posedge clock);
                #1 movimento_pronto = 1'b0;
            end
            prev = solicita_movimento;
        end
    end

    task automatic run_case(input string name);
        bit ok, mto, done;
        logic [2:0] fe;
        int nm, h;
        run_id++;
        model(ok, fe, nm, mto);
        mov_count = 0;
        last_len = 0;
        h = $urandom_range(1, 3);
        @(posedge clock);
        #1 iniciar = 1'b1;
        @(posedge clock);
        #1 iniciar = (h > 1);
        @(negedge clock);
        chk({name, "_lat0"}, inicia_captura, 0);
        @(posedge clock);
        #1 iniciar = (h > 2);
        @(negedge clock);
        chk({name, "_lat1"}, inicia_captura, 0);
        @(posedge clock);
        #1 iniciar = 1'b0;
        @(negedge clock);
        chk({name, "_lat2"}, inicia_captura, 1);
        done = 0;
        for (int i = 0; i < 3000 && !done; i++) begin
            @(negedge clock);
            done = pronto || erro;
        end
        chk({name, "_done"}, done, 1);
        @(negedge clock);
        chk({name, "_pronto"}, pronto, ok);
        chk({name, "_erro"}, erro, !ok);
        chk({name, "_face"}, face, fe);
        chk({name, "_db"}, db_estado, ok ? 7 : 8);
        chk({name, "_nmov"}, mov_count, nm);
        chk({name, "_left"}, sb.size(), 0);
        if (mto) chk({name, "_movlen"}, last_len, TO + 1);
        repeat (12) @(negedge clock);
        chk({name, "_hold"}, {pronto, erro, face}, {ok, !ok, fe});
    endtask

    initial begin
        #900_000;
        $display("FAIL watchdog expired expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok, mto, done;
        logic [2:0] fe;
        int nm, r;
        set_plan(0, 0);
        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("reset_state", {inicia_captura, solicita_movimento, pronto, erro, face, db_estado}, 0);
        @(posedge clock);
        #1 reset = 1'b0;

        set_plan(3, 4);
        run_case("nominal");
        set_plan(0, 0);
        cap_withhold[2] = 2;
        run_case("retry_f2");
        set_plan(0, 0);
        cap_withhold[1] = 3;
        run_case("capfail_f1");
        set_plan(0, 0);
        run_case("restart");
        set_plan(0, 0);
        mov_give[1] = 0;
        run_case("movfail_f1");
        set_plan(7, 0);
        run_case("edge_timeout");
        set_plan(7, 7);
        cap_withhold[3] = 2;
        run_case("edge_retry");

        for (int k = 0; k < 25; k++) begin
            set_plan(0, 0);
            for (int f = 0; f < NF; f++) begin
                r = $urandom_range(0, 9);
                cap_withhold[f] = (r < 6) ? 0 : (r < 8) ? 1 : (r == 8) ? 2 : 3;
                mov_give[f] = ($urandom_range(0, 15) != 0);
            end
            run_case("random");
        end

        set_plan(0, 0);
        mov_give[3] = 0;
        run_id++;
        model(ok, fe, nm, mto);
        @(posedge clock);
        #1 iniciar = 1'b1;
        @(posedge clock);
        #1 iniciar = 1'b0;
        done = 0;
        for (int i = 0; i < 3000 && !done; i++) begin
            @(negedge clock);
            done = solicita_movimento && face == 3;
        end
        chk("rst_reach_f3", done, 1);
        repeat (2) @(posedge clock);
        #1 reset = 1'b1;
        iniciar = 1'b1;
        @(posedge clock);
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            chk("rst_mid_move", {inicia_captura, solicita_movimento, pronto, erro, face, db_estado}, 0);
        end
        @(posedge clock);
        #1 reset = 1'b0;
        iniciar = 1'b0;
        sb.delete();
        set_plan(0, 0);
        run_case("post_reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
